// File: rtl/sr_using_jk.sv
// sr_using_jk: clocked SR flip-flop built from per-bit JK cores.
// Each bit maps S/R onto J/K, and the S=R=1 case is remapped by SR11_MODE.
// SR11_MODE: 0 = toggle, 1 = hold, 2 = force 0, 3 = force 1.
// Any other SR11_MODE value falls back to toggle, which is the native JK response.
// qbar is the inverted output of the same register, so qbar == ~q at every point after reset.

module sr_jk_core (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // JK characteristic equation: set on J, clear on K, toggle on both, hold on neither
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  // state register with synchronous reset taking priority over J/K
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

module sr_using_jk #(
  parameter int WIDTH     = 1,
  parameter int SR11_MODE = 0
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_core;

  // SR-to-JK conversion; only the forbidden S=R=1 combination is remapped
  always_comb begin
    j = s;
    k = r;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] && r[i]) begin
        case (SR11_MODE)
          1:       begin j[i] = 1'b0; k[i] = 1'b0; end
          2:       begin j[i] = 1'b0; k[i] = 1'b1; end
          3:       begin j[i] = 1'b1; k[i] = 1'b0; end
          default: begin j[i] = 1'b1; k[i] = 1'b1; end
        endcase
      end
    end
  end

  // one independent JK core per bit
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sr_jk_core u_core (
      .clk (clk),
      .rst (rst),
      .j   (j[g]),
      .k   (k[g]),
      .q   (q_core[g])
    );
  end

  assign q    = q_core;
  assign qbar = ~q_core;

endmodule

// File: tb/tb_sr_using_jk.sv
// Directed bench for sr_using_jk: mode 0/1/2/3 single-bit instances and a 4-bit mode 0 instance.
module tb_sr_using_jk;

  logic clk;
  logic rst;

  logic       s0, r0, q0, qb0;
  logic       sm, rm, q1, qb1, q2, qb2, q3, qb3;
  logic [3:0] s4, r4, q4, qb4;

  int n_checks;
  int n_fail;

  sr_using_jk #(.WIDTH(1), .SR11_MODE(0)) u_m0 (
    .s(s0), .r(r0), .clk(clk), .rst(rst), .q(q0), .qbar(qb0));
  sr_using_jk #(.WIDTH(1), .SR11_MODE(1)) u_m1 (
    .s(sm), .r(rm), .clk(clk), .rst(rst), .q(q1), .qbar(qb1));
  sr_using_jk #(.WIDTH(1), .SR11_MODE(2)) u_m2 (
    .s(sm), .r(rm), .clk(clk), .rst(rst), .q(q2), .qbar(qb2));
  sr_using_jk #(.WIDTH(1), .SR11_MODE(3)) u_m3 (
    .s(sm), .r(rm), .clk(clk), .rst(rst), .q(q3), .qbar(qb3));
  sr_using_jk #(.WIDTH(4), .SR11_MODE(0)) u_w4 (
    .s(s4), .r(r4), .clk(clk), .rst(rst), .q(q4), .qbar(qb4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // advance one posedge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // check q and qbar of the mode 0 single-bit instance
  task automatic chk0(input string tag, input logic exp_q);
    check({tag, " q"},    {3'b000, q0},  {3'b000, exp_q});
    check({tag, " qbar"}, {3'b000, qb0}, {3'b000, ~exp_q});
  endtask

  // check the mode 1/2/3 single-bit instances together
  task automatic chkm(input string tag, input logic e1, input logic e2, input logic e3);
    check({tag, " m1"}, {2'b00, qb1, q1}, {2'b00, ~e1, e1});
    check({tag, " m2"}, {2'b00, qb2, q2}, {2'b00, ~e2, e2});
    check({tag, " m3"}, {2'b00, qb3, q3}, {2'b00, ~e3, e3});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    s0 = 1'b0; r0 = 1'b0;
    sm = 1'b0; rm = 1'b0;
    s4 = 4'b0000; r4 = 4'b0000;
    #2;

    // reset
    tick();
    chk0("reset", 1'b0);
    chkm("reset", 1'b0, 1'b0, 1'b0);
    check("reset w4 q",    q4,  4'b0000);
    check("reset w4 qbar", qb4, 4'b1111);

    rst = 1'b0;
    tick();
    chk0("post-reset hold", 1'b0);

    // reset / hold / set / hold
    s0 = 1'b0; r0 = 1'b1; tick(); chk0("clear", 1'b0);
    s0 = 1'b0; r0 = 1'b0; tick(); chk0("hold0", 1'b0);
    s0 = 1'b1; r0 = 1'b0; tick(); chk0("set", 1'b1);
    s0 = 1'b0; r0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk0("hold1", 1'b1);
    end
    s0 = 1'b0; r0 = 1'b1; tick(); chk0("clear from 1", 1'b0);
    s0 = 1'b1; r0 = 1'b0; tick(); chk0("set again", 1'b1);

    // forbidden input, toggle mode: 0,1,0,1 starting from q=1
    s0 = 1'b1; r0 = 1'b1;
    tick(); chk0("toggle1", 1'b0);
    tick(); chk0("toggle2", 1'b1);
    tick(); chk0("toggle3", 1'b0);
    tick(); chk0("toggle4", 1'b1);

    // reset priority over a set request
    rst = 1'b1; s0 = 1'b1; r0 = 1'b0;
    tick(); chk0("rst over set", 1'b0);
    rst = 1'b0;
    tick(); chk0("set after rst", 1'b1);
    s0 = 1'b0; r0 = 1'b0;

    // modes 1/2/3 starting from q=1
    sm = 1'b1; rm = 1'b0; tick(); chkm("modes set", 1'b1, 1'b1, 1'b1);
    sm = 1'b1; rm = 1'b1; tick(); chkm("modes 11 from 1", 1'b1, 1'b0, 1'b1);
    tick(); chkm("modes 11 again", 1'b1, 1'b0, 1'b1);
    // modes 1/2/3 starting from q=0
    sm = 1'b0; rm = 1'b1; tick(); chkm("modes clear", 1'b0, 1'b0, 1'b0);
    sm = 1'b1; rm = 1'b1; tick(); chkm("modes 11 from 0", 1'b0, 0, 1'b1);
    sm = 1'b0; rm = 1'b0; tick(); chkm("modes hold", 1'b0, 1'b0, 1'b1);

    // 4-bit, independent bits
    s4 = 4'b0101; r4 = 4'b0011;
    tick();
    check("w4 step1 q",    q4,  4'b0101);
    check("w4 step1 qbar", qb4, 4'b1010);
    tick();
    check("w4 step2 q",    q4,  4'b0100);
    check("w4 step2 qbar", qb4, 4'b1011);
    s4 = 4'b1000; r4 = 4'b0100;
    tick();
    check("w4 step3 q",    q4,  4'b1000);
    s4 = 4'b0000; r4 = 4'b0000;
    tick();
    check("w4 hold q",     q4,  4'b1000);
    s4 = 4'b0000; r4 = 4'b1111;
    tick();
    check("w4 clear q",    q4,  4'b0000);
    check("w4 clear qbar", qb4, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
